// File: rtl/tiny_cpu_pkg.sv
// tiny_cpu_pkg: shared constants and types for the tiny CPU sequencer.
// Host command opcodes, CPU opcodes, memory geometry and FSM encoding.
package tiny_cpu_pkg;

  localparam int MEM_AW   = 5;
  localparam int MEM_DW   = 8;
  localparam int CPU_PC_W = 8;

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_RUN   = 2'b10;
  localparam logic [1:0] CMD_HALT  = 2'b11;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_JZ  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_HACC  = 2'b01,
    S_FETCH = 2'b10,
    S_EXEC  = 2'b11
  } state_t;

endpackage

// File: rtl/tiny_cpu_seq_ctrl_mem_port_mux.sv
// mem_port_mux: picks the single memory port owner from the sequencer state.
// In: state, host/fetch/cpu requests. Out: mem_addr, mem_we, mem_wdata.
import tiny_cpu_pkg::*;

module mem_port_mux #(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  state_t          state,
  input  logic [AW-1:0]   host_addr,
  input  logic            host_we,
  input  logic [DW-1:0]   host_wdata,
  input  logic [AW-1:0]   fetch_addr,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata
);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state)
      S_IDLE: ;
      S_HACC: begin
        mem_addr  = host_addr;
        mem_we    = host_we;
        mem_wdata = host_wdata;
      end
      S_FETCH: begin
        mem_addr = fetch_addr;
      end
      S_EXEC: begin
        if (cpu_req) begin
          mem_addr  = cpu_addr;
          mem_we    = cpu_we;
          mem_wdata = cpu_wdata;
        end
      end
    endcase
  end

endmodule

// File: rtl/tiny_cpu_seq_ctrl.sv
// tiny_cpu_seq_ctrl: FETCH/EXEC sequencer and host/CPU memory arbiter.
// Ports: host cmd/rsp, CPU pc + mem request, cpu_step/instr, memory port.
import tiny_cpu_pkg::*;

module tiny_cpu_seq_ctrl #(
  parameter int AW   = MEM_AW,
  parameter int DW   = MEM_DW,
  parameter int PC_W = CPU_PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_data,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_data,
  input  logic [PC_W-1:0] pc,
  input  logic            cpu_mem_req,
  input  logic            cpu_mem_we,
  input  logic [AW-1:0]   cpu_mem_addr,
  input  logic [DW-1:0]   cpu_mem_wdata,
  output logic            cpu_step,
  output logic [DW-1:0]   instr,
  output logic            running,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  state_t        state;
  state_t        state_n;
  logic          ret_fetch;
  logic          ret_n;
  logic          run_mode;
  logic          run_n;
  logic          host_last;
  logic          hl_n;
  logic          latch;
  logic          h_we;
  logic          h_rd;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_data;
  logic          acc;
  logic          acc_host;
  logic          acc_run;
  logic          acc_halt;

  // Fetch wraps modulo memory size; upper pc bits are ignored.
  logic pc_unused;
  assign pc_unused = ^pc[PC_W-1:AW];

  assign cmd_ready = (state == S_IDLE) | (state == S_EXEC);
  assign acc       = cmd_valid & cmd_ready;
  assign acc_host  = acc & ((cmd_op == CMD_WRITE) | (cmd_op == CMD_READ));
  assign acc_run   = acc & (cmd_op == CMD_RUN);
  assign acc_halt  = acc & (cmd_op == CMD_HALT);
  assign running   = run_mode & (state != S_IDLE);

  always_comb begin
    state_n  = state;
    ret_n    = ret_fetch;
    run_n    = run_mode;
    hl_n     = host_last;
    latch    = 1'b0;
    cpu_step = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (acc_host) begin
          state_n = S_HACC;
          ret_n   = 1'b0;
          latch   = 1'b1;
        end else if (acc_run) begin
          run_n   = cmd_data[0];
          state_n = S_FETCH;
        end
      end
      S_HACC: begin
        hl_n    = 1'b1;
        state_n = ret_fetch ? S_FETCH : S_IDLE;
      end
      S_FETCH: begin
        hl_n    = 1'b0;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        cpu_step = 1'b1;
        // Boundary priority: stop, then one host slot, else next fetch.
        if (acc_halt || !run_mode) begin
          state_n = S_IDLE;
          run_n   = 1'b0;
        end else if (acc_host && !host_last) begin
          state_n = S_HACC;
          ret_n   = 1'b1;
          latch   = 1'b1;
        end else begin
          state_n = S_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ret_fetch <= 1'b0;
      run_mode  <= 1'b0;
      host_last <= 1'b0;
      h_we      <= 1'b0;
      h_rd      <= 1'b0;
      h_addr    <= '0;
      h_data    <= '0;
    end else begin
      state     <= state_n;
      ret_fetch <= ret_n;
      run_mode  <= run_n;
      host_last <= hl_n;
      if (latch) begin
        h_we   <= (cmd_op == CMD_WRITE);
        h_rd   <= (cmd_op == CMD_READ);
        h_addr <= cmd_addr;
        h_data <= cmd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= (state == S_HACC) & h_rd;
      if (state == S_FETCH)
        instr <= mem_rdata;
      if ((state == S_HACC) && h_rd)
        rsp_data <= mem_rdata;
    end
  end

  mem_port_mux #(
    .AW(AW),
    .DW(DW)
  ) u_mux (
    .state      (state),
    .host_addr  (h_addr),
    .host_we    (h_we),
    .host_wdata (h_data),
    .fetch_addr (pc[AW-1:0]),
    .cpu_req    (cpu_mem_req),
    .cpu_we     (cpu_mem_we),
    .cpu_addr   (cpu_mem_addr),
    .cpu_wdata  (cpu_mem_wdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata)
  );

endmodule

// File: tb/tb_tiny_cpu_seq_ctrl.sv
// tb_tiny_cpu_seq_ctrl: scoreboard bench for the tiny CPU sequencer.
// Memory and a stub CPU are modelled here; expectations are queued by stimulus.
import tiny_cpu_pkg::*;

module tb_tiny_cpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] pc = 8'd0;
  logic       cpu_mem_req;
  logic       cpu_mem_we;
  logic [4:0] cpu_mem_addr;
  logic [7:0] cpu_mem_wdata;
  logic       cpu_step;
  logic [7:0] instr;
  logic       running;
  logic [4:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tiny_cpu_seq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .pc            (pc),
    .cpu_mem_req   (cpu_mem_req),
    .cpu_mem_we    (cpu_mem_we),
    .cpu_mem_addr  (cpu_mem_addr),
    .cpu_mem_wdata (cpu_mem_wdata),
    .cpu_step      (cpu_step),
    .instr         (instr),
    .running       (running),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  logic [7:0] mem [32] = '{default: 8'h00};
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk)
    if (mem_we) mem[mem_addr] <= mem_wdata;

  // Stub CPU: decodes LD/ST from the latched instruction, bumps pc per step.
  logic       pc_load = 1'b0;
  logic [7:0] pc_val  = 8'd0;
  assign cpu_mem_req   = (instr[7:6] == OP_LD) | (instr[7:6] == OP_ST);
  assign cpu_mem_we    = (instr[7:6] == OP_ST);
  assign cpu_mem_addr  = {1'b1, instr[3:0]};
  assign cpu_mem_wdata = 8'h5A;
  always @(posedge clk)
    if (pc_load) pc <= pc_val;
    else if (cpu_step) pc <= pc + 8'd1;

  typedef struct {
    logic [4:0] fa;
    logic [7:0] ins;
    logic [4:0] ea;
    logic       ewe;
    logic       ld;
    logic [7:0] rd;
    logic       run;
  } step_t;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  step_t      step_q[$];
  wr_t        wr_q[$];
  logic [7:0] rsp_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event want none @%0t", name, $time);
  endtask

  function automatic void exp_step(input logic [4:0] fa, input logic [7:0] ins,
                                   input logic [4:0] ea, input logic ewe,
                                   input logic ld, input logic [7:0] rd,
                                   input logic run);
    step_t s;
    s.fa = fa; s.ins = ins; s.ea = ea; s.ewe = ewe;
    s.ld = ld; s.rd = rd; s.run = run;
    step_q.push_back(s);
  endfunction

  function automatic void exp_wr(input logic [4:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wr_q.push_back(w);
  endfunction

  // Monitor: samples at negedge, pops expectations on DUT events.
  logic [4:0] prev_addr = '0;
  logic       wr_d1 = 1'b0;
  logic       rd_d1 = 1'b0;
  logic       rd_d2 = 1'b0;

  always @(negedge clk) begin
    step_t s;
    wr_t   w;
    logic  acc;
    if (!rst_n) begin
      wr_d1 = 1'b0; rd_d1 = 1'b0; rd_d2 = 1'b0; prev_addr = '0;
    end else begin
      acc = cmd_valid & cmd_ready;
      if (acc && running) chk("acc_in_exec", cpu_step, 1);
      if (mem_we) begin
        if (wr_q.size() == 0) fail("unexpected_write");
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", mem_addr, w.a);
          chk("wr_data", mem_wdata, w.d);
        end
        if (!cpu_step) chk("wr_latency", wr_d1, 1);
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) fail("unexpected_rsp");
        else chk("rsp_data", rsp_data, rsp_q.pop_front());
        chk("rsp_latency", rd_d2, 1);
      end
      if (cpu_step) begin
        if (step_q.size() == 0) fail("unexpected_step");
        else begin
          s = step_q.pop_front();
          chk("fetch_addr", prev_addr, s.fa);
          chk("instr", instr, s.ins);
          chk("exec_addr", mem_addr, s.ea);
          chk("exec_we", mem_we, s.ewe);
          chk("running", running, s.run);
          if (s.ld) chk("ld_data", mem_rdata, s.rd);
        end
      end
      rd_d2     = rd_d1;
      rd_d1     = acc & (cmd_op == CMD_READ);
      wr_d1     = acc & (cmd_op == CMD_WRITE);
      prev_addr = mem_addr;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail("ready_timeout");
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] a,
                      input logic [7:0] d);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic load_pc(input logic [7:0] v);
    @(posedge clk); #1;
    pc_val = v; pc_load = 1'b1;
    @(posedge clk); #1;
    pc_load = 1'b0;
  endtask

  task automatic wait_steps(input int n);
    int seen = 0;
    for (int i = 0; i < 100 && seen < n; i++) begin
      @(negedge clk);
      if (cpu_step) seen++;
    end
    if (seen < n) fail("step_timeout");
  endtask

  task automatic push_prog_steps();
    exp_step(5'd0, 8'h13, 5'd19, 1'b0, 1'b1, 8'h3C, 1'b1);
    exp_step(5'd1, 8'h80, 5'd0,  1'b0, 1'b0, 8'h00, 1'b1);
    exp_step(5'd2, 8'h45, 5'd21, 1'b1, 1'b0, 8'h00, 1'b1);
    exp_step(5'd3, 8'hC0, 5'd0,  1'b0, 1'b0, 8'h00, 1'b1);
    exp_wr(5'd21, 8'h5A);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_addr = '0; cmd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_cpu_step", cpu_step, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_running", running, 0);
    chk("rst_instr", instr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Host write then readback.
    exp_wr(5'd5, 8'hA7);
    send(CMD_WRITE, 5'd5, 8'hA7);
    rsp_q.push_back(8'hA7);
    send(CMD_READ, 5'd5, 8'h00);

    // Program: LD r1,[19]; ALU; ST [21]; JZ.
    exp_wr(5'd0, 8'h13);  send(CMD_WRITE, 5'd0, 8'h13);
    exp_wr(5'd19, 8'h3C); send(CMD_WRITE, 5'd19, 8'h3C);
    exp_wr(5'd1, 8'h80);  send(CMD_WRITE, 5'd1, 8'h80);
    exp_wr(5'd2, 8'h45);  send(CMD_WRITE, 5'd2, 8'h45);
    exp_wr(5'd3, 8'hC0);  send(CMD_WRITE, 5'd3, 8'hC0);

    // Single step.
    load_pc(8'd0);
    exp_step(5'd0, 8'h13, 5'd19, 1'b0, 1'b1, 8'h3C, 1'b0);
    send(CMD_RUN, 5'd0, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    chk("step_idle_running", running, 0);
    chk("step_idle_ready", cmd_ready, 1);
    chk("step_idle_addr", mem_addr, 0);

    // Continuous run, halt lands in EXEC of pc 3.
    load_pc(8'd0);
    push_prog_steps();
    send(CMD_RUN, 5'd0, 8'h01);
    wait_steps(3);
    send(CMD_HALT, 5'd0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("halt_running", running, 0);
    chk("halt_addr", mem_addr, 0);
    rsp_q.push_back(8'h5A);
    send(CMD_READ, 5'd21, 8'h00);

    // Host READ held while running: one access per instruction.
    exp_wr(5'd7, 8'h7E);
    send(CMD_WRITE, 5'd7, 8'h7E);
    load_pc(8'd0);
    push_prog_steps();
    repeat (3) rsp_q.push_back(8'h7E);
    send(CMD_RUN, 5'd0, 8'h01);
    cmd_valid = 1'b1; cmd_op = CMD_READ; cmd_addr = 5'd7;
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (cmd_ready) n++;
    end
    if (n < 3) fail("hold_timeout");
    @(posedge clk); #1;
    cmd_op = CMD_HALT;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_halt_running", running, 0);

    // pc above 31 wraps; halt in the first EXEC.
    load_pc(8'd37);
    exp_step(5'd5, 8'hA7, 5'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    send(CMD_RUN, 5'd0, 8'h01);
    send(CMD_HALT, 5'd0, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    chk("wrap_halt_running", running, 0);
    chk("wrap_halt_addr", mem_addr, 0);

    // Reset during a host write cycle.
    send(CMD_WRITE, 5'd9, 8'h55);
    rst_n = 1'b0;
    #1;
    chk("rstw_mem_we", mem_we, 0);
    chk("rstw_mem_addr", mem_addr, 0);
    chk("rstw_cmd_ready", cmd_ready, 1);
    chk("rstw_running", running, 0);
    chk("rstw_instr", instr, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstw_mem9", mem[9], 0);
    rsp_q.push_back(8'h00);
    send(CMD_READ, 5'd9, 8'h00);

    repeat (5) @(posedge clk);
    chk("step_q_empty", step_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
